// File: rtl/ram_write_arbiter_4core.sv
// ram_write_arbiter_4core: round-robin write port arbiter for four cores,
// plus a one-word-per-cycle clear sweep that zeroes the whole memory.
module ram_write_arbiter_4core #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 65536
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [3:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [ADDR_W-1:0] wr_addr2,
  input  logic [ADDR_W-1:0] wr_addr3,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [DATA_W-1:0] wr_data2,
  input  logic [DATA_W-1:0] wr_data3,
  output logic [3:0]        wr_ack,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [15:0]       wr_count
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [ADDR_W:0] SWEEP_END = (ADDR_W+1)'(DEPTH);
  state_t            state, state_nxt;
  logic [1:0]        rr_ptr, rr_nxt, gnt, idx;
  logic              gnt_v;
  logic [3:0]        elig, ack_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              busy_nxt, done_nxt, we_nxt;
  logic [ADDR_W-1:0] addr_nxt, sel_addr;
  logic [DATA_W-1:0] data_nxt, sel_data;
  logic [15:0]       count_nxt;
  // a core acked this cycle is masked so one request is never granted twice
  assign elig = wr_req & ~wr_ack;
  always_comb begin
    gnt   = rr_ptr;
    gnt_v = 1'b0;
    idx   = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (elig[idx]) begin
        gnt   = idx;
        gnt_v = 1'b1;
      end
    end
  end
  assign sel_addr = gnt == 2'd0 ? wr_addr0 : gnt == 2'd1 ? wr_addr1 : gnt == 2'd2 ? wr_addr2 : wr_addr3;
  assign sel_data = gnt == 2'd0 ? wr_data0 : gnt == 2'd1 ? wr_data1 : gnt == 2'd2 ? wr_data2 : wr_data3;
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    ack_nxt   = '0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = mem_addr;
    data_nxt  = mem_data;
    count_nxt = wr_count;
    if (state == CLEAR) begin
      // counter is one bit wider so a full 2^ADDR_W sweep still terminates
      if (cnt == SWEEP_END) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        busy_nxt = 1'b1;
        we_nxt   = 1'b1;
        addr_nxt = cnt[ADDR_W-1:0];
        data_nxt = '0;
        cnt_nxt  = cnt + 1'b1;
      end
    end else if (clear_start) begin
      state_nxt = CLEAR;
      busy_nxt  = 1'b1;
      cnt_nxt   = '0;
      count_nxt = '0;
    end else if (gnt_v) begin
      we_nxt    = 1'b1;
      addr_nxt  = sel_addr;
      data_nxt  = sel_data;
      ack_nxt   = 4'b0001 << gnt;
      rr_nxt    = gnt + 2'd1;
      count_nxt = wr_count + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      wr_ack     <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      wr_count   <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      cnt        <= cnt_nxt;
      wr_ack     <= ack_nxt;
      busy       <= busy_nxt;
      clear_done <= done_nxt;
      mem_we     <= we_nxt;
      mem_addr   <= addr_nxt;
      mem_data   <= data_nxt;
      wr_count   <= count_nxt;
    end
  end
endmodule

// File: doc/ram_write_arbiter_4core.md
Name: ram_write_arbiter_4core

Overview:
- Write-side companion to the shared 4-core 16-bit x 64K memory, which is read combinationally by the cores.
- Accepts write requests from up to four cores over a req/ack handshake and arbitrates them round-robin.
- Drives a single registered write port (we/addr/data) into the memory array.
- Owns a sequential clear sweep that zeroes the whole memory one word per cycle.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data word width in bits.
- DEPTH, 65536, number of words swept by the clear sequence (must be <= 2^ADDR_W).

Ports:
- clk  input  1  single system clock, rising edge.
- clear_n  input  1  asynchronous active-low reset.
- wr_req  input  4  per-core write request; bit i belongs to core i.
- wr_addr0..wr_addr3  input  ADDR_W each  write address for core i.
- wr_data0..wr_data3  input  DATA_W each  write data for core i.
- wr_ack  output  4  registered one-cycle acceptance pulse per core.
- clear_start  input  1  pulse that starts a full-memory zero sweep.
- busy  output  1  high while the clear sweep is running.
- clear_done  output  1  one-cycle pulse after the last sweep write.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory write address.
- mem_data  output  DATA_W  memory write data.
- wr_count  output  16  count of accepted core writes.

Behaviour:
- Reset (clear_n low, asynchronous):
  - State goes to IDLE; round-robin pointer rr_ptr = 0; sweep counter = 0.
  - All outputs are 0: wr_ack, busy, clear_done, mem_we, mem_addr, mem_data, wr_count.
  - A reset mid-sweep aborts the sweep; it does not resume after reset releases.
- States: IDLE and CLEAR.
- IDLE, no clear_start:
  - Eligible requesters are wr_req & ~wr_ack. A core whose ack is currently high is masked, so it cannot be granted twice for one request.
  - Priority order is rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4); the first eligible core wins.
  - On the rising edge: mem_we=1, mem_addr=wr_addrN, mem_data=wr_dataN, wr_ack=one-hot(N), rr_ptr=(N+1) mod 4, wr_count += 1 (wraps at 0xFFFF -> 0).
  - If no core is eligible: mem_we=0, wr_ack=0, and mem_addr/mem_data hold their last values.
  - Latency: the request is sampled at edge t, and the write and ack are both visible in cycle t+1.
- Handshake rules:
  - A core holds wr_req, wr_addr and wr_data stable until it sees its wr_ack.
  - It may drop wr_req in the ack cycle, or keep it high to issue a new request (new addr/data); a kept request becomes eligible one cycle after the ack.
  - Sustained throughput is one write per cycle across cores; with all four requesting continuously, each core gets one write every 4 cycles.
- clear_start has priority over pending requests. In IDLE with clear_start=1, the next edge:
  - moves to CLEAR, sets busy=1, counter=0, wr_count=0;
  - asserts no ack that cycle, and mem_we=0.
- CLEAR:
  - Each edge drives mem_we=1, mem_addr=counter, mem_data=0, then counter+1.
  - The edge that issues address DEPTH-1 is the last sweep write.
  - The following edge returns to IDLE: busy=0, clear_done=1 for one cycle, mem_we=0.
  - Sweep length is DEPTH write cycles; the sweep cycle count is DEPTH+2 including entry and exit.
  - clear_start while in CLEAR is ignored.
  - wr_ack stays 0 for the whole sweep; requests stay pending and are arbitrated from the current rr_ptr once back in IDLE.
  - In the clear_done cycle arbitration resumes normally, so a grant issued on that edge appears one cycle later.
- Simultaneous same-address requests are serialized in round-robin order; the last granted write wins in memory.
- Widths: the counter is ADDR_W+1 bits internally so DEPTH = 2^ADDR_W terminates correctly; mem_addr takes its low ADDR_W bits.

Test Plan:
- Reset, then wr_req=4'b0001, wr_addr0=16'h0010, wr_data0=16'hABCD -> next cycle mem_we=1, mem_addr=0x0010, mem_data=0xABCD, wr_ack=4'b0001, wr_count=1; drop req -> mem_we=0 following cycle.
- wr_req=4'b1111 held continuously, distinct addresses -> acks in order 0001,0010,0100,1000,0001..., one mem_we per cycle, no core acked on consecutive cycles, wr_count=8 after 8 grants.
- rr_ptr=2 (after granting core 1), then wr_req=4'b0011 -> core 0 granted first, then core 1.
- DEPTH=16: clear_start pulse while wr_req=4'b0100 pending -> busy=1, 16 writes addr 0..15 data 0, no wr_ack during sweep, then clear_done pulse and wr_count=0; core 2 acked next cycle.
- Assert clear_n low at sweep address 7 -> all outputs 0 immediately; after release busy stays 0, no further sweep writes.
- Core 1 and core 3 both request addr 0x0042 with data 0x1111/0x3333, rr_ptr=3 -> core 3 written first, core 1 second; final memory value 0x1111.
